// File: rtl/alu_issue_stage.sv
// alu_issue_stage -- one-entry issue register in front of the ALU.
//
// Decodes an RV32-style instruction into ALU controls, selects operands and
// holds the result in a single register stage (latency 1) with valid/ready
// handshakes on both sides.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   in_valid / in_ready        decoded instruction handshake
//   opcode, funct3, funct7b5   instruction fields used for decode
//   rs1, rs2, rd               register specifiers
//   rs1_data, rs2_data, imm    register file values and immediate
//   flush                      drop the held entry and block capture
//   ex_ready                   ALU stage accepts the held entry
//   ALUResult                  live ALU output of the held entry
//   exmem_*, memwb_*           downstream destinations for hazard checks
//   out_valid                  held entry is valid
//   SrcA, SrcB, ALUCtrl        operands and ALU op (ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5)
//   rd_out, regwrite_out, memread_out, illegal_out   entry side-band
//
// Build option
//   FORWARD_EN  defined: operands forwarded from own/exmem/memwb, stall only
//               on load-use. Undefined: operands from register file only,
//               stall while any consumed source has a pending writer.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic        flush,
  input  logic        ex_ready,
  input  logic [31:0] ALUResult,
  input  logic [4:0]  exmem_rd,
  input  logic        exmem_regwrite,
  input  logic [31:0] exmem_result,
  input  logic [4:0]  memwb_rd,
  input  logic        memwb_regwrite,
  input  logic [31:0] memwb_result,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  output logic [2:0]  ALUCtrl,
  output logic [4:0]  rd_out,
  output logic        regwrite_out,
  output logic        memread_out,
  output logic        illegal_out
);

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                         ALU_OR  = 3'b011, ALU_XOR = 3'b100, ALU_SLT = 3'b101;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I  = 7'b0010011, OP_LD  = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111;

  // ---------------- decode ----------------
  logic       f3_ok;
  logic [2:0] f3_ctrl;
  always_comb begin
    f3_ok   = 1'b1;
    f3_ctrl = ALU_ADD;
    case (funct3)
      3'b000:  f3_ctrl = ALU_ADD;
      3'b111:  f3_ctrl = ALU_AND;
      3'b110:  f3_ctrl = ALU_OR;
      3'b100:  f3_ctrl = ALU_XOR;
      3'b010:  f3_ctrl = ALU_SLT;
      default: f3_ok   = 1'b0;
    endcase
  end

  logic [2:0] dec_ctrl;
  logic dec_srcb_imm, dec_srca_zero, dec_rw, dec_mr, dec_ill, use_rs1, use_rs2;
  always_comb begin
    dec_ctrl      = ALU_ADD;
    dec_srcb_imm  = 1'b0;
    dec_srca_zero = 1'b0;
    dec_rw        = 1'b0;
    dec_mr        = 1'b0;
    dec_ill       = 1'b0;
    use_rs1       = 1'b0;
    use_rs2       = 1'b0;
    case (opcode)
      OP_R: if (f3_ok) begin
        dec_ctrl = (funct3 == 3'b000 && funct7b5) ? ALU_SUB : f3_ctrl;
        dec_rw   = 1'b1;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end else dec_ill = 1'b1;
      OP_I: if (f3_ok) begin
        dec_ctrl     = f3_ctrl;
        dec_srcb_imm = 1'b1;
        dec_rw       = 1'b1;
        use_rs1      = 1'b1;
      end else dec_ill = 1'b1;
      OP_LD: begin
        dec_srcb_imm = 1'b1;
        dec_rw       = 1'b1;
        dec_mr       = 1'b1;
        use_rs1      = 1'b1;
      end
      OP_ST: begin
        // rs2 carries store data, so it still counts as a consumed source
        dec_srcb_imm = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
      end
      OP_BR: begin
        dec_ctrl = ALU_SUB;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OP_LUI: begin
        dec_srca_zero = 1'b1;
        dec_srcb_imm  = 1'b1;
        dec_rw        = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
    if (rd == 5'd0) dec_rw = 1'b0;
  end

  // ---------------- hazard detection ----------------
  // regwrite_out is never set with rd_out==0, so own_wr implies a real dest.
  logic own_wr;
  assign own_wr = out_valid && regwrite_out;

  logic own1, own2, ex1, ex2, wb1, wb2;
  assign own1 = own_wr && (rs1 != 5'd0) && (rs1 == rd_out);
  assign own2 = own_wr && (rs2 != 5'd0) && (rs2 == rd_out);
  assign ex1  = exmem_regwrite && (rs1 != 5'd0) && (rs1 == exmem_rd);
  assign ex2  = exmem_regwrite && (rs2 != 5'd0) && (rs2 == exmem_rd);
  assign wb1  = memwb_regwrite && (rs1 != 5'd0) && (rs1 == memwb_rd);
  assign wb2  = memwb_regwrite && (rs2 != 5'd0) && (rs2 == memwb_rd);

  logic        stall;
  logic [31:0] op_a, op_b;

`ifdef FORWARD_EN
  // Only a load in the own slot cannot be forwarded: its data is not in ALUResult.
  assign stall = in_valid && out_valid && memread_out &&
                 ((use_rs1 && own1) || (use_rs2 && own2));

  always_comb begin
    op_a = rs1_data;
    if (rs1 == 5'd0) op_a = 32'd0;
    else if (own1)   op_a = ALUResult;
    else if (ex1)    op_a = exmem_result;
    else if (wb1)    op_a = memwb_result;
    op_b = rs2_data;
    if (rs2 == 5'd0) op_b = 32'd0;
    else if (own2)   op_b = ALUResult;
    else if (ex2)    op_b = exmem_result;
    else if (wb2)    op_b = memwb_result;
  end
`else
  // Wait until every pending writer of a consumed source has retired.
  assign stall = in_valid && ((use_rs1 && (own1 || ex1 || wb1)) ||
                              (use_rs2 && (own2 || ex2 || wb2)));
  assign op_a  = rs1_data;
  assign op_b  = rs2_data;

  logic unused_fwd;
  assign unused_fwd = ^{ALUResult, exmem_result, memwb_result, memread_out};
`endif

  // Ready is held high while in reset; anything "captured" then is lost anyway.
  assign in_ready = !rst_n || ((!out_valid || ex_ready) && !stall && !flush);

  // ---------------- issue register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      SrcA         <= '0;
      SrcB         <= '0;
      ALUCtrl      <= ALU_ADD;
      rd_out       <= '0;
      regwrite_out <= 1'b0;
      memread_out  <= 1'b0;
      illegal_out  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid    <= 1'b1;
      SrcA         <= dec_srca_zero ? 32'd0 : op_a;
      SrcB         <= dec_srcb_imm ? imm : op_b;
      ALUCtrl      <= dec_ctrl;
      rd_out       <= rd;
      regwrite_out <= dec_rw;
      memread_out  <= dec_mr;
      illegal_out  <= dec_ill;
    end else if (ex_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage -- directed, table-driven bench for alu_issue_stage.
module tb_alu_issue_stage;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I  = 7'b0010011, OP_LD  = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111,
                         OP_BAD = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, funct7b5, flush, ex_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd, exmem_rd, memwb_rd;
  logic [31:0] rs1_data, rs2_data, imm, ALUResult, exmem_result, memwb_result;
  logic        exmem_regwrite, memwb_regwrite;
  logic        in_ready, out_valid, regwrite_out, memread_out, illegal_out;
  logic [31:0] SrcA, SrcB;
  logic [2:0]  ALUCtrl;
  logic [4:0]  rd_out;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .rs1(rs1), .rs2(rs2), .rd(rd), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .imm(imm), .flush(flush), .ex_ready(ex_ready),
    .ALUResult(ALUResult), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .exmem_result(exmem_result), .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .memwb_result(memwb_result), .in_ready(in_ready), .out_valid(out_valid),
    .SrcA(SrcA), .SrcB(SrcB), .ALUCtrl(ALUCtrl), .rd_out(rd_out),
    .regwrite_out(regwrite_out), .memread_out(memread_out), .illegal_out(illegal_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  r1, r2, rd;
    logic [31:0] d1, d2, imm;
    logic [2:0]  ctrl;
    logic [31:0] a, b;
    logic        rw, mr, ill, chk_ab;
  } vec_t;

  int n_chk = 0, n_fail = 0;

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdx,
                              input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im,
                              input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                              input logic rw, input logic mr, input logic ill, input logic ab);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.r1 = r1; v.r2 = r2; v.rd = rdx;
    v.d1 = d1; v.d2 = d2; v.imm = im; v.ctrl = ctrl; v.a = a; v.b = b;
    v.rw = rw; v.mr = mr; v.ill = ill; v.chk_ab = ab;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdx,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im);
    opcode = op; funct3 = f3; funct7b5 = f7; rs1 = r1; rs2 = r2; rd = rdx;
    rs1_data = d1; rs2_data = d2; imm = im; in_valid = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " SrcA"}, SrcA, 32'd0);
    chk({tag, " SrcB"}, SrcB, 32'd0);
    chk({tag, " ALUCtrl"}, {29'd0, ALUCtrl}, 32'd0);
    chk({tag, " rd_out"}, {27'd0, rd_out}, 32'd0);
    chk({tag, " rw/mr/ill"}, {29'd0, regwrite_out, memread_out, illegal_out}, 32'd0);
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  vec_t vt[17];

  initial begin
    // decode table: one instruction at a time, each followed by a bubble
    vt[0]  = mk(OP_R,  3'b000, 1'b0, 5'd1, 5'd2, 5'd3,  32'd7,   32'd5,  32'd0,   3'd0, 32'd7,   32'd5,   1'b1, 1'b0, 1'b0, 1'b1);
    vt[1]  = mk(OP_R,  3'b000, 1'b1, 5'd1, 5'd2, 5'd4,  32'd20,  32'd3,  32'd0,   3'd1, 32'd20,  32'd3,   1'b1, 1'b0, 1'b0, 1'b1);
    vt[2]  = mk(OP_R,  3'b111, 1'b0, 5'd1, 5'd2, 5'd5,  32'hF0,  32'h3C, 32'd0,   3'd2, 32'hF0,  32'h3C,  1'b1, 1'b0, 1'b0, 1'b1);
    vt[3]  = mk(OP_R,  3'b110, 1'b0, 5'd1, 5'd2, 5'd5,  32'hF0,  32'h3C, 32'd0,   3'd3, 32'hF0,  32'h3C,  1'b1, 1'b0, 1'b0, 1'b1);
    vt[4]  = mk(OP_R,  3'b100, 1'b0, 5'd1, 5'd2, 5'd5,  32'hF0,  32'h3C, 32'd0,   3'd4, 32'hF0,  32'h3C,  1'b1, 1'b0, 1'b0, 1'b1);
    vt[5]  = mk(OP_R,  3'b010, 1'b0, 5'd1, 5'd2, 5'd5,  32'd1,   32'd2,  32'd0,   3'd5, 32'd1,   32'd2,   1'b1, 1'b0, 1'b0, 1'b1);
    vt[6]  = mk(OP_I,  3'b000, 1'b1, 5'd1, 5'd9, 5'd6,  32'd50,  32'd77, 32'd100, 3'd0, 32'd50,  32'd100, 1'b1, 1'b0, 1'b0, 1'b1);
    vt[7]  = mk(OP_I,  3'b111, 1'b0, 5'd1, 5'd9, 5'd6,  32'd50,  32'd77, 32'hFF,  3'd2, 32'd50,  32'hFF,  1'b1, 1'b0, 1'b0, 1'b1);
    vt[8]  = mk(OP_I,  3'b010, 1'b0, 5'd1, 5'd9, 5'd6,  32'd50,  32'd77, 32'd60,  3'd5, 32'd50,  32'd60,  1'b1, 1'b0, 1'b0, 1'b1);
    vt[9]  = mk(OP_LD, 3'b010, 1'b0, 5'd1, 5'd9, 5'd5,  32'd100, 32'd77, 32'd8,   3'd0, 32'd100, 32'd8,   1'b1, 1'b1, 1'b0, 1'b1);
    vt[10] = mk(OP_ST, 3'b010, 1'b0, 5'd1, 5'd2, 5'd7,  32'd100, 32'd44, 32'd12,  3'd0, 32'd100, 32'd12,  1'b0, 1'b0, 1'b0, 1'b1);
    vt[11] = mk(OP_BR, 3'b000, 1'b0, 5'd1, 5'd2, 5'd8,  32'd9,   32'd9,  32'd16,  3'd1, 32'd9,   32'd9,   1'b0, 1'b0, 1'b0, 1'b1);
    vt[12] = mk(OP_LUI,3'b101, 1'b0, 5'd3, 5'd9, 5'd10, 32'd55,  32'd77, 32'h12345000, 3'd0, 32'd0, 32'h12345000, 1'b1, 1'b0, 1'b0, 1'b1);
    vt[13] = mk(OP_R,  3'b000, 1'b0, 5'd1, 5'd2, 5'd0,  32'd7,   32'd5,  32'd0,   3'd0, 32'd7,   32'd5,   1'b0, 1'b0, 1'b0, 1'b1);
    vt[14] = mk(OP_R,  3'b001, 1'b0, 5'd1, 5'd2, 5'd3,  32'd7,   32'd5,  32'd0,   3'd0, 32'd0,   32'd0,   1'b0, 1'b0, 1'b1, 1'b0);
    vt[15] = mk(OP_BAD,3'b000, 1'b0, 5'd1, 5'd2, 5'd3,  32'd7,   32'd5,  32'd0,   3'd0, 32'd0,   32'd0,   1'b0, 1'b0, 1'b1, 1'b0);
    vt[16] = mk(OP_I,  3'b001, 1'b0, 5'd1, 5'd2, 5'd3,  32'd7,   32'd5,  32'd4,   3'd0, 32'd0,   32'd0,   1'b0, 1'b0, 1'b1, 1'b0);

    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    opcode = '0; funct3 = '0; funct7b5 = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
    rs1_data = '0; rs2_data = '0; imm = '0; ALUResult = '0;
    exmem_rd = '0; exmem_regwrite = 1'b0; exmem_result = '0;
    memwb_rd = '0; memwb_regwrite = 1'b0; memwb_result = '0;

    // reset state; an instruction offered during reset must be discarded
    #1 rst_n = 1'b0;
    drive(OP_R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd7, 32'd5, 32'd0);
    #1 chk_all_zero("reset");
    tick;
    chk("reset_discard out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    // first edge after release with in_valid=1 captures
    tick;
    chk("first_cap out_valid", {31'd0, out_valid}, 32'd1);
    chk("first_cap SrcA", SrcA, 32'd7);
    in_valid = 1'b0;
    tick;

    // decode table
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].op, vt[i].f3, vt[i].f7, vt[i].r1, vt[i].r2, vt[i].rd, vt[i].d1, vt[i].d2, vt[i].imm);
      #1 chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      tick;
      chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d ALUCtrl", i), {29'd0, ALUCtrl}, {29'd0, vt[i].ctrl});
      chk($sformatf("v%0d rd_out", i), {27'd0, rd_out}, {27'd0, vt[i].rd});
      chk($sformatf("v%0d rw/mr/ill", i), {29'd0, regwrite_out, memread_out, illegal_out},
          {29'd0, vt[i].rw, vt[i].mr, vt[i].ill});
      if (vt[i].chk_ab) begin
        chk($sformatf("v%0d SrcA", i), SrcA, vt[i].a);
        chk($sformatf("v%0d SrcB", i), SrcB, vt[i].b);
      end
      in_valid = 1'b0;
      tick;
      chk($sformatf("v%0d bubble", i), {31'd0, out_valid}, 32'd0);
    end

    // add x3,x1,x2 then dependent sub x4,x3,x1
    drive(OP_R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd7, 32'd5, 32'd0);
    tick;
    chk("add SrcA", SrcA, 32'd7);
    chk("add SrcB", SrcB, 32'd5);
    chk("add ctrl/rd/rw", {24'd0, ALUCtrl, rd_out}, {24'd0, 3'd0, 5'd3});
    chk("add regwrite", {31'd0, regwrite_out}, 32'd1);
    drive(OP_R, 3'b000, 1'b1, 5'd3, 5'd1, 5'd4, 32'd99, 32'd7, 32'd0);
    ALUResult = 32'd12;
`ifdef FORWARD_EN
    #1 chk("raw no_stall", {31'd0, in_ready}, 32'd1);
    tick;
`else
    #1 chk("raw stall1", {31'd0, in_ready}, 32'd0);
    tick;
    exmem_rd = 5'd3; exmem_regwrite = 1'b1; exmem_result = 32'd12;
    #1 chk("raw stall2", {31'd0, in_ready}, 32'd0);
    tick;
    exmem_regwrite = 1'b0; memwb_rd = 5'd3; memwb_regwrite = 1'b1; memwb_result = 32'd12;
    #1 chk("raw stall3", {31'd0, in_ready}, 32'd0);
    tick;
    memwb_regwrite = 1'b0;
    #1 chk("raw release", {31'd0, in_ready}, 32'd1);
    tick;
`endif
    chk("sub out_valid", {31'd0, out_valid}, 32'd1);
`ifdef FORWARD_EN
    chk("sub SrcA", SrcA, 32'd12);
`else
    chk("sub SrcA", SrcA, 32'd99);
`endif
    chk("sub SrcB", SrcB, 32'd7);
    chk("sub ALUCtrl", {29'd0, ALUCtrl}, 32'd1);
    in_valid = 1'b0;
    tick;

    // lw x5,8(x1) then and x6,x5,x2 (load-use)
    drive(OP_LD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5, 32'd100, 32'd0, 32'd8);
    tick;
    chk("lw memread", {31'd0, memread_out}, 32'd1);
    drive(OP_R, 3'b111, 1'b0, 5'd5, 5'd2, 5'd6, 32'd55, 32'd3, 32'd0);
    #1 chk("lu stall1", {31'd0, in_ready}, 32'd0);
    tick;
    exmem_rd = 5'd5; exmem_regwrite = 1'b1; exmem_result = 32'd108;
`ifdef FORWARD_EN
    #1 chk("lu release", {31'd0, in_ready}, 32'd1);
    tick;
    chk("and SrcA", SrcA, 32'd108);
`else
    #1 chk("lu stall2", {31'd0, in_ready}, 32'd0);
    tick;
    exmem_regwrite = 1'b0; memwb_rd = 5'd5; memwb_regwrite = 1'b1; memwb_result = 32'd108;
    #1 chk("lu stall3", {31'd0, in_ready}, 32'd0);
    tick;
    memwb_regwrite = 1'b0;
    #1 chk("lu release", {31'd0, in_ready}, 32'd1);
    tick;
    chk("and SrcA", SrcA, 32'd55);
`endif
    exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
    chk("and SrcB", SrcB, 32'd3);
    chk("and ALUCtrl", {29'd0, ALUCtrl}, 32'd2);
    in_valid = 1'b0;
    tick;

    // back-pressure: hold for 4 cycles, then advance on the same edge as capture
    drive(OP_R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd7, 32'd10, 32'd20, 32'd0);
    tick;
    ex_ready = 1'b0;
    drive(OP_R, 3'b110, 1'b0, 5'd11, 5'd12, 5'd8, 32'd1, 32'd2, 32'd0);
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("hold%0d in_ready", k), {31'd0, in_ready}, 32'd0);
      tick;
      chk($sformatf("hold%0d out_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("hold%0d SrcA/B", k), SrcA ^ (SrcB << 8), 32'd10 ^ (32'd20 << 8));
      chk($sformatf("hold%0d rd/ctrl", k), {24'd0, ALUCtrl, rd_out}, {24'd0, 3'd0, 5'd7});
    end
    ex_ready = 1'b1;
    #1 chk("adv in_ready", {31'd0, in_ready}, 32'd1);
    tick;
    chk("adv SrcA", SrcA, 32'd1);
    chk("adv rd/ctrl", {24'd0, ALUCtrl, rd_out}, {24'd0, 3'd3, 5'd8});

    // flush concurrent with a valid offer
    drive(OP_R, 3'b100, 1'b0, 5'd1, 5'd2, 5'd9, 32'd4, 32'd4, 32'd0);
    flush = 1'b1;
    #1 chk("flush in_ready", {31'd0, in_ready}, 32'd0);
    tick;
    chk("flush out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush dropped", {27'd0, rd_out}, 32'd8);
    flush = 1'b0; in_valid = 1'b0;
    tick;

    // reset in the middle of a load-use stall with a held entry
    drive(OP_LD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd10, 32'd100, 32'd0, 32'd4);
    tick;
    chk("pre_rst out_valid", {31'd0, out_valid}, 32'd1);
    drive(OP_R, 3'b000, 1'b0, 5'd10, 5'd2, 5'd11, 32'd1, 32'd1, 32'd0);
    ex_ready = 1'b0;
    #1 chk("pre_rst stall", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    tick;
    rst_n = 1'b1; in_valid = 1'b0; ex_ready = 1'b1;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
